rv_muldiv: RTL and testbench

RV_MULDIV -- requirements
Module: rv_muldiv

---
 rtl/rv_muldiv.sv | 193 +++++++++++++++++++
 tb/tb_rv_muldiv.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv.sv
// rv_muldiv: RV32M multiply/divide unit, one bit per cycle.
// Define RV_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
package rv_pkg;
  localparam int XLEN = 32;
endpackage

module rv_muldiv #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] res_q;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            valid_q;

  logic            a_sgn;
  logic            b_sgn;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic            neg_d;
  logic [XLEN-1:0] quick;

  // Operand decode: signedness, magnitudes and early-exit cases
  always_comb begin
    a_sgn = (op_i == 3'b001) || (op_i == 3'b010) ||
            (op_i == 3'b100) || (op_i == 3'b110);
    b_sgn = (op_i == 3'b001) || (op_i == 3'b100) ||
            (op_i == 3'b110);
    sa    = a_sgn & a_i[XLEN-1];
    sb    = b_sgn & b_i[XLEN-1];
    a_mag = sa ? -a_i : a_i;
    b_mag = sb ? -b_i : b_i;
    div_zero = op_i[2] && (b_i == '0);
    ovf = op_i[2] && !op_i[0] &&
          (a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
          (b_i == '1);
    neg_d = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
    if (div_zero)
      quick = op_i[1] ? a_i : '1;
    else
      quick = op_i[1] ? '0 : a_i;
  end

`ifdef RV_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa;
  logic [2*XLEN-1:0] fb;
  logic [2*XLEN-1:0] fp;
  logic [XLEN-1:0]   fast_res;

  // Sign-extended full-width product, truncated to 2*XLEN
  always_comb begin
    fa = {{XLEN{sa}}, a_i};
    fb = {{XLEN{sb}}, b_i};
    fp = fa * fb;
    fast_res = (op_i[1:0] == 2'b00) ? fp[XLEN-1:0]
                                    : fp[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]     msum;
  logic [XLEN:0]     sh;
  logic              ge;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   fin;

  // One shift-add or restoring-divide step, plus final sign fixup
  always_comb begin
    msum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    sh   = {hi, lo[XLEN-1]};
    ge   = sh >= {1'b0, opb};
    if (op_q[2]) begin
      hi_n = ge ? (sh[XLEN-1:0] - opb) : sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = msum[XLEN:1];
      lo_n = {msum[0], lo[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_n : lo_n;
    r_s    = neg_q ? -hi_n : hi_n;
    if (op_q[2])
      fin = op_q[1] ? r_s : q_s;
    else if (op_q[1:0] == 2'b00)
      fin = prod_s[XLEN-1:0];
    else
      fin = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM with datapath registers and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      res_q   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            op_q  <= op_i;
            neg_q <= neg_d;
            hi    <= '0;
            lo    <= op_i[2] ? a_mag : b_mag;
            opb   <= op_i[2] ? b_mag : a_mag;
            cnt   <= '0;
            if (div_zero || ovf) begin
              state   <= DONE;
              valid_q <= 1'b1;
              res_q   <= quick;
`ifdef RV_MULDIV_FAST_MUL_EN
            end else if (!op_i[2]) begin
              state   <= DONE;
              valid_q <= 1'b1;
              res_q   <= fast_res;
`endif
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state   <= DONE;
            valid_q <= 1'b1;
            res_q   <= fin;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state == IDLE);
  assign busy_o   = (state != IDLE);
  assign valid_o  = valid_q;
  assign result_o = valid_q ? res_q : '0;

endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: directed vectors for rv_muldiv.
// Multiply latency follows RV_MULDIV_FAST_MUL_EN.
module tb_rv_muldiv;

`ifdef RV_MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  rv_muldiv #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request now; accept edge is cycle 0.
  // Returns with the result sitting in DONE.
  task automatic start_op(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int n);
    op_i = op;
    a_i = a;
    b_i = b;
    valid_i = 1'b1;
    chk({tag, " rdy"}, 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    op_i = ~op;
    a_i = 32'hdead_beef;
    b_i = 32'h0bad_f00d;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (n == 1)
        chk({tag, " busy"}, 32'(busy_o), 32'd1);
    end while (!valid_o && n < 100);
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] er,
                       input int el);
    int n;
    start_op(tag, op, a, b, n);
    chk({tag, " lat"}, 32'(n), 32'(el));
    chk({tag, " res"}, result_o, er);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    chk({tag, " idle"}, 32'(ready_o), 32'd1);
    chk({tag, " vlo"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst_i = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    op_i = 3'd0;
    a_i = '0;
    b_i = '0;
    #12;
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    rst_i = 1'b0;

    do_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, ML);
    do_op("mul_neg", 3'b000, 32'hffff_ffff, 32'd2,
          32'hffff_fffe, ML);
    do_op("mulh_neg", 3'b001, 32'hffff_ffff, 32'd2,
          32'hffff_ffff, ML);
    do_op("mulhsu", 3'b010, 32'hffff_ffff, 32'd2,
          32'hffff_ffff, ML);
    do_op("mulhu", 3'b011, 32'hffff_ffff, 32'd2,
          32'h0000_0001, ML);
    do_op("div_m7", 3'b100, 32'hffff_fff9, 32'd2,
          32'hffff_fffd, 33);
    do_op("rem_m7", 3'b110, 32'hffff_fff9, 32'd2,
          32'hffff_ffff, 33);
    do_op("div_7n2", 3'b100, 32'd7, 32'hffff_fffe,
          32'hffff_fffd, 33);
    do_op("rem_7n2", 3'b110, 32'd7, 32'hffff_fffe,
          32'd1, 33);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op("divu_max", 3'b101, 32'hffff_ffff, 32'd1,
          32'hffff_ffff, 33);
    do_op("divu_z", 3'b101, 32'h1234_5678, 32'd0,
          32'hffff_ffff, 1);
    do_op("remu_z", 3'b111, 32'h1234_5678, 32'd0,
          32'h1234_5678, 1);
    do_op("div_z", 3'b100, 32'd5, 32'd0,
          32'hffff_ffff, 1);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hffff_ffff,
          32'h8000_0000, 1);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hffff_ffff,
          32'd0, 1);

    // backpressure
    start_op("bp", 3'b100, 32'hffff_fff9, 32'd2, n);
    chk("bp lat", 32'(n), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp valid", 32'(valid_o), 32'd1);
      chk("bp res", result_o, 32'hffff_fffd);
      chk("bp ready", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    chk("bp release", 32'(ready_o), 32'd1);

    // flush at CALC cycle 10 with a competing request
    op_i = 3'b101;
    a_i = 32'd1000;
    b_i = 32'd3;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("fl busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    valid_i = 1'b1;
    op_i = 3'b000;
    a_i = 32'd3;
    b_i = 32'd3;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl ready", 32'(ready_o), 32'd1);
    chk("fl busy0", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o || busy_o) seen++;
    end
    chk("fl quiet", 32'(seen), 32'd0);
    do_op("fl next", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    // async reset mid-CALC
    op_i = 3'b101;
    a_i = 32'd1000;
    b_i = 32'd3;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar ready", 32'(ready_o), 32'd1);
    chk("ar busy", 32'(busy_o), 32'd0);
    chk("ar valid", 32'(valid_o), 32'd0);
    chk("ar res", result_o, 32'd0);
    rst_i = 1'b0;
    do_op("ar mulhu", 3'b011, 32'hffff_ffff, 32'hffff_ffff,
          32'hffff_fffe, ML);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
